frame_seq_ctrl: RTL and testbench

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

---
 rtl/frame_seq_pkg.sv | 30 +++
 rtl/cyc_timer.sv | 43 ++++
 rtl/frame_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// frame_seq_pkg
// Shared definitions for the frame sequencer: FSM state encoding, default
// parameter values and a width helper for the cycle timers.
// Optional feature macro used by the design: FRAME_SEQ_TIMEOUT_EN (watchdog).
// -----------------------------------------------------------------------------
package frame_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        FINISH    = 3'd4
    } frame_seq_state_t;

    localparam int DEF_CNT_W          = 32'sd16;
    localparam int DEF_GAP_CYCLES     = 32'sd1000;
    localparam int DEF_TIMEOUT_CYCLES = 32'sd420000;

    // Bits needed to hold max_val, never less than one.
    function automatic int timer_width(input int max_val);
        if (max_val < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/cyc_timer.sv
// -----------------------------------------------------------------------------
// cyc_timer
// Loadable count-down timer. A load writes load_val; while en is high the
// count decrements toward zero and stops there. expired is high in any
// enabled, non-load cycle in which the count already reads zero, so a timer
// loaded with N expires in the (N+1)-th enabled cycle after the load.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load, load_val  reload strobe and value
//   en              count enable
//   expired         count reached zero while enabled
// -----------------------------------------------------------------------------
module cyc_timer
    import frame_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_r;

    // Count-down register with load priority over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && !load && (cnt_r == '0);

endmodule

// File: rtl/frame_seq_ctrl.sv
// -----------------------------------------------------------------------------
// frame_seq_ctrl
// Launches a run of video frames on a stream source: one src_begin pulse per
// frame, waits for src_done, idles GAP_CYCLES+1 cycles, repeats until the
// requested count is reached (frame_num=0 runs until stop).
// Optional feature: define FRAME_SEQ_TIMEOUT_EN to add a watchdog on the
// wait for src_done; without it timeout_err is constant 0.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start, stop  sequence start / stop-after-current-frame pulses
//   frame_num    frames to run (0 = continuous)
//   src_begin    frame launch pulse to the source
//   src_done     end-of-frame pulse from the source
//   busy         high whenever not idle
//   frame_cnt    frames completed in the current/last sequence
//   seq_done     pulse when a sequence ends normally
//   timeout_err  sticky watchdog flag
// -----------------------------------------------------------------------------
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] frame_num,
    output logic             src_begin,
    input  logic             src_done,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             seq_done,
    output logic             timeout_err
);

    localparam int GAP_W = timer_width(GAP_CYCLES);

    frame_seq_state_t state_r;
    frame_seq_state_t state_s;

    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             stop_req_r;
    logic             src_begin_r;
    logic             busy_r;
    logic             seq_done_r;

    logic             start_acc_s;
    logic             frame_done_s;
    logic             stop_set_s;
    logic             last_frame_s;
    logic             gap_load_s;
    logic             gap_en_s;
    logic             gap_exp_s;

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int WD_W = timer_width(TIMEOUT_CYCLES);
    logic wd_load_s;
    logic wd_en_s;
    logic wd_exp_s;
    logic timeout_s;
    logic timeout_err_r;
`endif

    assign cnt_inc_s    = frame_cnt_r + CNT_W'(1'b1);
    // Compare against the post-increment count; target 0 never terminates.
    assign last_frame_s = (target_r != '0) && (cnt_inc_s == target_r);
    assign gap_en_s     = (state_r == GAP);

    // The gap timer is loaded while leaving WAIT_DONE, so GAP lasts
    // GAP_CYCLES+1 cycles (one cycle when GAP_CYCLES is 0).
    cyc_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load_s),
        .load_val (GAP_W'(GAP_CYCLES)),
        .en       (gap_en_s),
        .expired  (gap_exp_s)
    );

`ifdef FRAME_SEQ_TIMEOUT_EN
    // Loaded in LAUNCH with TIMEOUT_CYCLES-1 so it fires in the
    // TIMEOUT_CYCLES-th WAIT_DONE cycle.
    assign wd_load_s = (state_r == LAUNCH);
    assign wd_en_s   = (state_r == WAIT_DONE);

    cyc_timer #(.W(WD_W)) u_wd_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load_s),
        .load_val (WD_W'(TIMEOUT_CYCLES - 32'sd1)),
        .en       (wd_en_s),
        .expired  (wd_exp_s)
    );
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_s      = state_r;
        start_acc_s  = 1'b0;
        frame_done_s = 1'b0;
        stop_set_s   = 1'b0;
        gap_load_s   = 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
        timeout_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_s     = LAUNCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: begin
                stop_set_s = stop;
                state_s    = WAIT_DONE;
            end
            WAIT_DONE: begin
                stop_set_s = stop;
                if (src_done) begin
                    frame_done_s = 1'b1;
                    // A stop arriving with src_done still ends the run here.
                    if (stop_req_r || stop || last_frame_s) begin
                        state_s = FINISH;
                    end else begin
                        state_s    = GAP;
                        gap_load_s = 1'b1;
                    end
                end
`ifdef FRAME_SEQ_TIMEOUT_EN
                else if (wd_exp_s) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end
`endif
                else begin
                    state_s = WAIT_DONE;
                end
            end
            GAP: begin
                if (stop) begin
                    state_s = FINISH;
                end else if (gap_exp_s) begin
                    state_s = LAUNCH;
                end else begin
                    state_s = GAP;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequence bookkeeping: target, completed-frame count, pending stop
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r    <= '0;
            frame_cnt_r <= '0;
            stop_req_r  <= 1'b0;
        end else if (start_acc_s) begin
            target_r    <= frame_num;
            frame_cnt_r <= '0;
            stop_req_r  <= 1'b0;
        end else begin
            target_r    <= target_r;
            frame_cnt_r <= frame_done_s ? cnt_inc_s : frame_cnt_r;
            stop_req_r  <= stop_req_r | stop_set_s;
        end
    end

    // Outputs registered from the next state so they line up with state_r
    always_ff @(posedge clk) begin
        if (rst) begin
            src_begin_r <= 1'b0;
            busy_r      <= 1'b0;
            seq_done_r  <= 1'b0;
        end else begin
            src_begin_r <= (state_s == LAUNCH);
            busy_r      <= (state_s != IDLE);
            seq_done_r  <= (state_s == FINISH);
        end
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    // Sticky watchdog flag, cleared by reset or an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else if (start_acc_s) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_err_r | timeout_s;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign src_begin = src_begin_r;
    assign busy      = busy_r;
    assign seq_done  = seq_done_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_seq_ctrl
// Directed sequence of scenarios with randomized frame lengths. The bench
// plays the video source itself, so expected counts, pulse totals and the
// launch spacing (2 + frame length + GAP) follow from simple arithmetic.
// -----------------------------------------------------------------------------
module tb_frame_seq_ctrl;

    localparam int CW  = 4;
    localparam int GAP = 3;
    localparam int TMO = 60;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] frame_num;
    logic          src_begin;
    logic          src_done;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic          seq_done;
    logic          timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_begin  = 0;
    int n_done   = 0;
    int exp_begin = 0;
    int exp_done  = 0;
    int t, t_prev, f, f_prev, snap;

    frame_seq_ctrl #(
        .CNT_W(CW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .frame_num(frame_num), .src_begin(src_begin), .src_done(src_done),
        .busy(busy), .frame_cnt(frame_cnt), .seq_done(seq_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Cycle counter and pulse tallies
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_begin) n_begin <= n_begin + 1;
        if (seq_done)  n_done  <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic start_seq(input int n);
        start = 1'b1;
        frame_num = CW'(n);
        @(negedge clk);
        start = 1'b0;
        check("cnt_cleared", 32'(frame_cnt), 32'd0);
    endtask

    // Find the next launch pulse, bounded.
    task automatic wait_begin(output int tb);
        int k;
        k = 0;
        while (!src_begin && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("begin_seen", 32'(src_begin), 32'd1);
        tb = cyc;
    endtask

    // Play one frame: src_done fl cycles after src_begin, optional stop at
    // cycle stop_at, optional ignored start at start_at, optional stray
    // src_done in the first cycle after the frame.
    task automatic do_frame(input int fl, input int stop_at, input int start_at,
                            input bit ghost, input int ecnt, input bit edone);
        for (int k = 1; k <= fl; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("begin_width", 32'(src_begin), 32'd0);
                check("busy_in_frame", 32'(busy), 32'd1);
            end
            stop     = (k == stop_at);
            start    = (k == start_at);
            if (k == start_at) frame_num = CW'(1);
            src_done = (k == fl);
        end
        @(negedge clk);
        stop     = 1'b0;
        start    = 1'b0;
        src_done = ghost;
        check("frame_cnt", 32'(frame_cnt), 32'(ecnt));
        check("seq_done", 32'(seq_done), 32'(edone));
        if (ghost) begin
            @(negedge clk);
            src_done = 1'b0;
        end
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_begins"}, 32'(n_begin), 32'(exp_begin));
        check({tag, "_dones"}, 32'(n_done), 32'(exp_done));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; src_done = 1'b0; frame_num = '0;
        repeat (3) @(negedge clk);
        check("rst_src_begin", 32'(src_begin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        // reset wins over a coincident start
        start = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", 32'(busy), 32'd0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);

        // A: three-frame sequence, spacing and final handshake
        start_seq(3);
        for (int i = 1; i <= 3; i++) begin
            wait_begin(t);
            if (i > 1) check("spacing_a", 32'(t - t_prev), 32'(f_prev + GAP + 2));
            f = $urandom_range(12, 3);
            do_frame(f, 0, 0, (i < 3) ? bit'($urandom_range(1, 0)) : 1'b0, i, i == 3);
            t_prev = t; f_prev = f;
        end
        @(negedge clk);
        check("a_busy_drop", 32'(busy), 32'd0);
        check("a_done_width", 32'(seq_done), 32'd0);
        src_done = 1'b1;
        @(negedge clk);
        src_done = 1'b0;
        repeat (8) @(negedge clk);
        check("a_cnt_hold", 32'(frame_cnt), 32'd3);
        exp_begin += 3; exp_done += 1;
        check_totals("a");

        // B: continuous run past counter wrap, ignored start, stop mid-frame
        start_seq(0);
        for (int i = 1; i <= 18; i++) begin
            wait_begin(t);
            if (i > 1) check("spacing_b", 32'(t - t_prev), 32'(f_prev + GAP + 2));
            f = $urandom_range(12, 3);
            if (i == 18)     do_frame(f, 2, 0, 1'b0, i % 16, 1'b1);
            else if (i == 5) do_frame(f, 0, 2, 1'b0, i % 16, 1'b0);
            else             do_frame(f, 0, 0, bit'($urandom_range(1, 0)), i % 16, 1'b0);
            t_prev = t; f_prev = f;
        end
        @(negedge clk);
        check("b_busy_drop", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        exp_begin += 18; exp_done += 1;
        check_totals("b");

        // C: stop during the gap after frame 2
        start_seq(0);
        for (int i = 1; i <= 2; i++) begin
            wait_begin(t);
            do_frame($urandom_range(12, 3), 0, 0, 1'b0, i, 1'b0);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("c_seq_done", 32'(seq_done), 32'd1);
        check("c_frame_cnt", 32'(frame_cnt), 32'd2);
        @(negedge clk);
        check("c_busy_drop", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        exp_begin += 2; exp_done += 1;
        check_totals("c");

        // D: single frame, stop coincident with src_done
        start_seq(1);
        wait_begin(t);
        f = $urandom_range(12, 3);
        do_frame(f, f, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        check("d_done_width", 32'(seq_done), 32'd0);
        check("d_busy_drop", 32'(busy), 32'd0);
        exp_begin += 1; exp_done += 1;
        check_totals("d");

        // E: reset during frame 2 aborts silently; then a start while busy
        start_seq(5);
        wait_begin(t);
        do_frame($urandom_range(12, 3), 0, 0, 1'b0, 1, 1'b0);
        wait_begin(t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("e_src_begin", 32'(src_begin), 32'd0);
        check("e_busy", 32'(busy), 32'd0);
        check("e_frame_cnt", 32'(frame_cnt), 32'd0);
        check("e_seq_done", 32'(seq_done), 32'd0);
        check("e_timeout", 32'(timeout_err), 32'd0);
        repeat (5) @(negedge clk);
        exp_begin += 2;
        check_totals("e_abort");
        start_seq(2);
        wait_begin(t);
        do_frame($urandom_range(12, 3), 0, 2, 1'b0, 1, 1'b0);
        wait_begin(t);
        do_frame($urandom_range(12, 3), 0, 0, 1'b0, 2, 1'b1);
        @(negedge clk);
        exp_begin += 2; exp_done += 1;
        check_totals("e");

`ifdef FRAME_SEQ_TIMEOUT_EN
        // Watchdog: src_done withheld for TMO cycles of WAIT_DONE
        start_seq(1);
        wait_begin(t);
        snap = n_done;
        repeat (TMO) @(negedge clk);
        check("wd_pre_err", 32'(timeout_err), 32'd0);
        check("wd_pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wd_err", 32'(timeout_err), 32'd1);
        check("wd_idle", 32'(busy), 32'd0);
        check("wd_no_done", 32'(n_done), 32'(snap));
        start_seq(1);
        check("wd_err_cleared", 32'(timeout_err), 32'd0);
        wait_begin(t);
        do_frame($urandom_range(12, 3), 0, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        exp_begin += 2; exp_done += 1;
        check_totals("wd");
`else
        check("no_wd_flag", 32'(timeout_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
